// File: rtl/sync_fifo_flagged.sv
// Parametrised show-ahead synchronous FIFO with registered level flags,
// programmable almost-full/almost-empty levels and sticky error flags.
module sync_fifo_flagged #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter int AF_THRESHOLD = DEPTH - 1,
  parameter int AE_THRESHOLD = 1,
  parameter int DATA_FF_OUT  = 0,
  parameter int CWIDTH       = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_err_clear,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic              o_full,
  output logic [CWIDTH-1:0] o_word_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     w_rd_nxt;
  logic [PW-1:0]     w_wr_nxt;
  logic [CWIDTH-1:0] r_count;
  logic [CWIDTH-1:0] w_cnt_nxt;
  logic              r_empty;
  logic              r_full;
  logic              r_aempty;
  logic              r_afull;
  logic              r_ovf;
  logic              r_udf;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_ovf_set;
  logic              w_udf_set;

  always_comb begin
    w_pop_ok  = i_pop & ~r_empty;
    w_push_ok = i_push & (~r_full | w_pop_ok);
    // explicit wrap so non-power-of-two depths work
    w_rd_nxt  = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
    w_wr_nxt  = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    w_cnt_nxt = r_count + CWIDTH'(w_push_ok) - CWIDTH'(w_pop_ok);
    w_ovf_set = i_push & r_full & ~w_pop_ok & ~i_clear;
    w_udf_set = i_pop & r_empty;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= w_wr_nxt;
      if (w_pop_ok)  r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_empty  <= (w_cnt_nxt == '0);
      r_aempty <= (w_cnt_nxt <= CWIDTH'(AE_THRESHOLD));
      r_afull  <= (w_cnt_nxt >= CWIDTH'(AF_THRESHOLD));
      r_full   <= (w_cnt_nxt == CWIDTH'(DEPTH));
    end
  end

  // set beats clear so a same-cycle event is never lost
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (i_err_clear) r_ovf <= 1'b0;
      if (w_udf_set)        r_udf <= 1'b1;
      else if (i_err_clear) r_udf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clear && !i_rst) r_mem[r_wr_ptr] <= i_data;
  end

  generate
    if (DATA_FF_OUT != 0) begin : g_ff
      logic [WIDTH-1:0] r_head;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_head <= '0;
        end else if (!i_clear) begin
          if (r_empty && w_push_ok)
            r_head <= i_data;
          else if (w_pop_ok && r_count >= CWIDTH'(2))
            r_head <= r_mem[w_rd_nxt];
          else if (w_pop_ok && w_push_ok)
            r_head <= i_data;
        end
      end
      assign o_data = r_head;
    end else begin : g_comb
      assign o_data = r_mem[r_rd_ptr];
    end
  endgenerate

  assign o_empty        = r_empty;
  assign o_almost_empty = r_aempty;
  assign o_almost_full  = r_afull;
  assign o_full         = r_full;
  assign o_word_count   = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;

endmodule
